// File: rtl/route_pkg.sv
// Shared constants and state encoding for the RouteData sequencer.
package route_pkg;

  localparam int N_ENT_DEF   = 10;
  localparam int ADDR_W_DEF  = 4;
  localparam int LUT_LAT_DEF = 2;
  localparam int SRAM_LAT    = 1;
  localparam int CNT_W       = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_M1  = 4'd1,
    ST_LOAD     = 4'd2,
    ST_READ     = 4'd3,
    ST_WAIT_LUT = 4'd4,
    ST_WRITE    = 4'd5,
    ST_STREAM   = 4'd6,
    ST_DRAIN    = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

endpackage

// File: rtl/route_lat_cnt.sv
// Loadable down-counter that times the LUT latency window; zero flags the last wait cycle.
module route_lat_cnt
  import route_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/route_data_seq.sv
// Sequencer driving RouteData for one M1/sigmoid layer pass or a GSRAM stream pass.
// Outputs are registered from the next-state decode, so they track the state register exactly.
module route_data_seq
  import route_pkg::*;
#(
  parameter int N_ENT   = N_ENT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LUT_LAT = LUT_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_sel,
  input  logic              m1_valid,
  output logic              reg_load_en,
  output logic              reg_load_sel,
  output logic [ADDR_W-1:0] addr,
  output logic              data_out_sel,
  output logic              sram_rd_en,
  output logic              lut_in_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENT - 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(LUT_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;

  logic              reg_load_en_q, reg_load_en_d;
  logic              reg_load_sel_q, reg_load_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              data_out_sel_q, data_out_sel_d;
  logic              sram_rd_en_q, sram_rd_en_d;
  logic              lut_in_valid_q, lut_in_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  route_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero_s)
  );

  // Next-state, index and latency-counter control.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = {ADDR_W{1'b0}};
          state_d = src_sel ? ST_STREAM : ST_WAIT_M1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_M1: begin
        if (m1_valid) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_WAIT_M1;
        end
      end
      ST_LOAD: state_d = ST_READ;
      ST_READ: begin
        state_d    = ST_WAIT_LUT;
        cnt_load_s = 1'b1;
      end
      ST_WAIT_LUT: begin
        if (cnt_zero_s) begin
          state_d = ST_WRITE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_READ;
        end
      end
      // idx stops on the last entry so it never wraps.
      ST_STREAM: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        idx_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Output decode of the upcoming state; first WAIT_LUT / later STREAM cycles use the current state.
  always_comb begin
    reg_load_en_d  = 1'b0;
    reg_load_sel_d = 1'b0;
    addr_d         = {ADDR_W{1'b0}};
    data_out_sel_d = 1'b0;
    sram_rd_en_d   = 1'b0;
    lut_in_valid_d = 1'b0;
    done_d         = 1'b0;
    busy_d         = (state_d != ST_IDLE);
    case (state_d)
      ST_LOAD: reg_load_en_d = 1'b1;
      ST_READ: addr_d = idx_d;
      ST_WAIT_LUT: begin
        addr_d         = idx_d;
        lut_in_valid_d = (state_q == ST_READ);
      end
      ST_WRITE: begin
        reg_load_en_d  = 1'b1;
        reg_load_sel_d = 1'b1;
        addr_d         = idx_d;
      end
      ST_STREAM: begin
        sram_rd_en_d   = 1'b1;
        data_out_sel_d = 1'b1;
        addr_d         = idx_d;
        lut_in_valid_d = (state_q == ST_STREAM);
      end
      ST_DRAIN: begin
        data_out_sel_d = 1'b1;
        lut_in_valid_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: addr_d = {ADDR_W{1'b0}};
    endcase
  end

  // State, index and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= {ADDR_W{1'b0}};
      reg_load_en_q  <= 1'b0;
      reg_load_sel_q <= 1'b0;
      addr_q         <= {ADDR_W{1'b0}};
      data_out_sel_q <= 1'b0;
      sram_rd_en_q   <= 1'b0;
      lut_in_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      reg_load_en_q  <= reg_load_en_d;
      reg_load_sel_q <= reg_load_sel_d;
      addr_q         <= addr_d;
      data_out_sel_q <= data_out_sel_d;
      sram_rd_en_q   <= sram_rd_en_d;
      lut_in_valid_q <= lut_in_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign reg_load_en  = reg_load_en_q;
  assign reg_load_sel = reg_load_sel_q;
  assign addr         = addr_q;
  assign data_out_sel = data_out_sel_q;
  assign sram_rd_en   = sram_rd_en_q;
  assign lut_in_valid = lut_in_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_route_data_seq.sv
// Bench: RouteData + GSRAM + y=2*x LUT models around route_data_seq, with a per-cycle output scoreboard.
module tb_route_data_seq;

  localparam int NE = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       src_sel = 1'b0;
  logic       m1_valid = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       reg_load_en, reg_load_sel, data_out_sel, sram_rd_en, lut_in_valid, busy, done;
  logic [3:0] addr;

  always #5 clk = ~clk;

  route_data_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_sel      (src_sel),
    .m1_valid     (m1_valid),
    .reg_load_en  (reg_load_en),
    .reg_load_sel (reg_load_sel),
    .addr         (addr),
    .data_out_sel (data_out_sel),
    .sram_rd_en   (sram_rd_en),
    .lut_in_valid (lut_in_valid),
    .busy         (busy),
    .done         (done)
  );

  logic [15:0] regs     [NE];
  logic [15:0] m1_val   [NE];
  logic [15:0] sram_mem [NE];
  int          wr_cnt   [NE];
  logic [15:0] rd_q, sram_q, p1, p2, data_out, sig_fb;
  logic [10:0] out_vec;

  assign data_out = data_out_sel ? sram_q : rd_q;
  assign sig_fb   = {p2[14:0], 1'b0};
  assign out_vec  = {reg_load_en, reg_load_sel, addr, data_out_sel, sram_rd_en, lut_in_valid, busy, done};

  // RouteData register file, SRAM read port and two-stage LUT.
  always @(posedge clk) begin : mdl
    int a;
    a = int'(addr);
    rd_q <= (a < NE) ? regs[a] : 16'h0bad;
    if (sram_rd_en) sram_q <= (a < NE) ? sram_mem[a] : 16'h0bad;
    p1 <= data_out;
    p2 <= p1;
    if (clr_cnt) begin
      for (int k = 0; k < NE; k++) wr_cnt[k] <= 0;
    end
    if (reg_load_en) begin
      if (reg_load_sel) begin
        if (a < NE) begin
          regs[a]   <= sig_fb;
          wr_cnt[a] <= wr_cnt[a] + 1;
        end
      end else begin
        for (int k = 0; k < NE; k++) regs[k] <= m1_val[k];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [10:0] exp_q[$];
  logic [15:0] lut_q[$];
  logic [15:0] wr_q[$];

  // Scoreboard: one expected output vector per cycle, plus LUT input and writeback data.
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("trace", 32'(out_vec), 32'(exp_q.pop_front()));
    if (lut_in_valid) begin
      if (lut_q.size() > 0) chk("lut_in", 32'(data_out), 32'(lut_q.pop_front()));
      else chk("lut_extra", 32'(lut_in_valid), 32'd0);
    end
    if (reg_load_en && reg_load_sel) begin
      if (wr_q.size() > 0) chk("wr_data", 32'(sig_fb), 32'(wr_q.pop_front()));
      else chk("wr_extra", 32'(reg_load_sel), 32'd0);
    end
  end

  function automatic logic [10:0] mk(logic en, logic sel, int a, logic dos, logic rd, logic lv, logic b, logic d);
    logic [3:0] a4;
    a4 = 4'(a);
    return {en, sel, a4, dos, rd, lv, b, d};
  endfunction

  // Expected outputs for cycle c of an M1 pass whose LOAD lands on cycle l (start high on cycle 0).
  function automatic logic [10:0] exp_m1(int c, int l);
    int r;
    int e;
    if (c == 0) return 11'd0;
    if (c < l) return mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (c == l) return mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (c <= l + 4 * NE) begin
      r = c - l - 1;
      e = r / 4;
      case (r % 4)
        0: return mk(1'b0, 1'b0, e, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        1: return mk(1'b0, 1'b0, e, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        2: return mk(1'b0, 1'b0, e, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        default: return mk(1'b1, 1'b1, e, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      endcase
    end
    if (c == l + 4 * NE + 1) return mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    return 11'd0;
  endfunction

  function automatic logic [10:0] exp_st(int c);
    if (c >= 1 && c <= NE) return mk(1'b0, 1'b0, c - 1, 1'b1, 1'b1, (c >= 2), 1'b1, 1'b0);
    if (c == NE + 1) return mk(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    if (c == NE + 2) return mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    return 11'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tick();
  endtask

  // One M1 pass; restart_rel/rst_rel are offsets from LOAD, negative means unused.
  task automatic run_m1(input int m1_dly, input int restart_rel, input int rst_rel);
    int l;
    int rs;
    int rr;
    int last;
    int n_ent;
    l     = ((m1_dly < 1) ? 1 : m1_dly) + 1;
    rs    = (rst_rel >= 0) ? l + rst_rel : -1;
    rr    = (restart_rel >= 0) ? l + restart_rel : -1;
    last  = (rs >= 0) ? rs + 1 : l + 4 * NE + 2;
    n_ent = (rs >= 0) ? (rst_rel - 2) / 4 : NE;
    for (int e = 0; e < n_ent; e++) wr_q.push_back(16'(m1_val[e] << 1));
    for (int e = 0; e < ((rs >= 0) ? n_ent + 1 : NE); e++) lut_q.push_back(m1_val[e]);
    for (int c = 0; c <= last; c++) exp_q.push_back((rs >= 0 && c > rs) ? 11'd0 : exp_m1(c, l));
    for (int c = 0; c <= last; c++) begin
      start    = (c == 0) || (c == rr);
      src_sel  = (c == rr);
      m1_valid = (c >= m1_dly);
      rst      = (c == rs);
      tick();
    end
    start    = 1'b0;
    src_sel  = 1'b0;
    m1_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    chk("lut_q_left", 32'(lut_q.size()), 32'd0);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic run_stream();
    for (int e = 0; e < NE; e++) lut_q.push_back(sram_mem[e]);
    for (int c = 0; c <= NE + 3; c++) exp_q.push_back(exp_st(c));
    for (int c = 0; c <= NE + 3; c++) begin
      start    = (c == 0);
      src_sel  = (c == 0);
      m1_valid = 1'b1;
      tick();
    end
    start    = 1'b0;
    src_sel  = 1'b0;
    m1_valid = 1'b0;
    tick();
    chk("st_exp_left", 32'(exp_q.size()), 32'd0);
    chk("st_lut_left", 32'(lut_q.size()), 32'd0);
  endtask

  task automatic check_slots(input int n_done);
    for (int k = 0; k < NE; k++) begin
      if (k < n_done) begin
        chk($sformatf("slot%0d", k), 32'(regs[k]), 32'(16'(m1_val[k] << 1)));
        chk($sformatf("wrcnt%0d", k), 32'(wr_cnt[k]), 32'd1);
      end else begin
        chk($sformatf("slot%0d_m1", k), 32'(regs[k]), 32'(m1_val[k]));
        chk($sformatf("wrcnt%0d", k), 32'(wr_cnt[k]), 32'd0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NE; k++) sram_mem[k] = 16'(16'h0100 + 7 * k);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_out", 32'(out_vec), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_out", 32'(out_vec), 32'd0);

    // Basic M1 pass, m1_valid three cycles after start.
    for (int k = 0; k < NE; k++) m1_val[k] = 16'(k + 1);
    clear_counts();
    run_m1(3, -1, -1);
    check_slots(NE);

    run_stream();

    // Ignored start during WAIT_LUT of entry 3.
    for (int k = 0; k < NE; k++) m1_val[k] = 16'(3 * k + 5);
    clear_counts();
    run_m1(3, 14, -1);
    check_slots(NE);

    // Reset during WAIT_LUT of entry 5, then a fresh pass.
    for (int k = 0; k < NE; k++) m1_val[k] = 16'(100 + k);
    clear_counts();
    run_m1(3, -1, 22);
    check_slots(5);
    for (int k = 0; k < NE; k++) m1_val[k] = 16'(7 * k + 1);
    clear_counts();
    run_m1(3, -1, -1);
    check_slots(NE);

    // start and m1_valid together.
    for (int k = 0; k < NE; k++) m1_val[k] = 16'(k * k + 2);
    clear_counts();
    run_m1(0, -1, -1);
    check_slots(NE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
